regfile_2r1w: RTL and testbench

Parametrised register file: DEPTH words of WIDTH bits, one write port, two independent registered read ports, and an on-chip bulk-initialise sequencer. It generalises the team's 8 x 1-bit decoder/mux register block to arbitrary width and depth and adds write-to-read bypass, an optional hardwired-zero register, and a multi-cycle fill operation with a busy flag. It is the operand store for the lab datapath: the control unit writes results and reads two operands per cycle.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_rport.sv | 52 +++++
 rtl/regfile_2r1w.sv | 146 ++++++++++++++
 tb/tb_regfile_2r1w.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the 2-read/1-write register file and its read ports.
// The sequencer only ever idles or sweeps, so a single state bit is enough.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } seq_state_e;

    // DEPTH=2 already gives 1 from $clog2; the guard keeps degenerate depths at least 1 bit wide.
    function automatic int calc_aw(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_rport.sv
// One registered read port: range check, hardwired-zero mask, write-first bypass and the output flop.
module regfile_rport
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter bit ZERO_REG = 1'b0,
    localparam int AW      = calc_aw(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] mem_i [DEPTH],
    input  logic [AW-1:0]    rsel_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] q_o
);

    logic             in_range;
    logic             masked;
    logic             hit;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    assign in_range = (32'(rsel_i) < DEPTH);
    assign masked   = !in_range || (ZERO_REG && (rsel_i == '0));
    assign hit      = we_i && (waddr_i == rsel_i);

    // A write landing on the address being read this cycle wins over the stored word.
    always_comb begin
        q_d = '0;
        if (!masked) begin
            if (hit) begin
                q_d = wdata_i;
            end else begin
                q_d = mem_i[rsel_i];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/regfile_2r1w.sv
// DEPTH x WIDTH register file with one write port, two registered read ports and a bulk-fill sequencer.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter bit ZERO_REG = 1'b0,
    localparam int AW      = calc_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             enable,
    input  logic [AW-1:0]    wsel,
    input  logic [WIDTH-1:0] d,
    input  logic [AW-1:0]    rsel_a,
    input  logic [AW-1:0]    rsel_b,
    output logic [WIDTH-1:0] qa,
    output logic [WIDTH-1:0] qb,
    input  logic             init_req,
    input  logic [WIDTH-1:0] init_val,
    output logic             busy,
    output logic             wr_drop
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    seq_state_e       state_q;
    logic [AW-1:0]    idx_q;
    logic [WIDTH-1:0] fill_q;
    logic             busy_q;
    logic             wr_drop_d;
    logic             wr_drop_q;

    logic             wsel_in_range;
    logic             idx_last;
    logic             port_we;
    logic             seq_we;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;

    assign wsel_in_range = (32'(wsel) < DEPTH);
    assign idx_last      = (32'(idx_q) == DEPTH - 1);

    // The port and the sequencer never write in the same cycle: the port is locked out while sweeping.
    assign port_we = enable && (state_q == IDLE) && wsel_in_range && !(ZERO_REG && (wsel == '0));
    assign seq_we  = (state_q == SWEEP) && !(ZERO_REG && (idx_q == '0));

    always_comb begin
        we    = port_we || seq_we;
        waddr = wsel;
        wdata = d;
        if (state_q == SWEEP) begin
            waddr = idx_q;
            wdata = fill_q;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Fill sequencer: one register per cycle, ending after the write to the last index.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            idx_q   <= '0;
            fill_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (init_req) begin
                        state_q <= SWEEP;
                        busy_q  <= 1'b1;
                        idx_q   <= '0;
                        fill_q  <= init_val;
                    end
                end
                SWEEP: begin
                    if (idx_last) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        idx_q   <= '0;
                    end else begin
                        idx_q <= idx_q + AW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Zero-register writes are dropped quietly; only busy or out-of-range requests are flagged.
    assign wr_drop_d = enable && (busy_q || !wsel_in_range);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_drop_q <= 1'b0;
        end else begin
            wr_drop_q <= wr_drop_d;
        end
    end

    regfile_rport #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_rport_a (
        .clk_i   (clk),
        .rst_i   (clr),
        .mem_i   (mem_q),
        .rsel_i  (rsel_a),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .q_o     (qa)
    );

    regfile_rport #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_rport_b (
        .clk_i   (clk),
        .rst_i   (clr),
        .mem_i   (mem_q),
        .rsel_i  (rsel_b),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .q_o     (qb)
    );

    assign busy    = busy_q;
    assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench driving two register files (8 deep plain, 6 deep with hardwired zero) from the same stimulus,
// checked against a per-instance behavioural model plus a few fixed vectors and hand sequences.
module tb_regfile_2r1w;

    typedef struct {
        logic       en;
        logic [2:0] ws;
        logic [7:0] dd;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [7:0] expQa;
        logic [7:0] expQb;
        logic       expDrop;
        logic       expBusy;
    } VecT;

    logic       clk = 1'b0;
    logic       clr;
    logic       enable;
    logic       initReq;
    logic [2:0] wsel;
    logic [2:0] rselA;
    logic [2:0] rselB;
    logic [7:0] d;
    logic [7:0] initVal;
    logic [7:0] qa0, qb0, qa1, qb1;
    logic       busy0, busy1, drop0, drop1;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [7:0] modelMem [2][8];
    int         depthOf  [2] = '{8, 6};
    bit         zeroOf   [2] = '{1'b0, 1'b1};
    int         fillLeft [2];
    logic [7:0] fillVal  [2];
    logic [7:0] expQa    [2];
    logic [7:0] expQb    [2];
    logic       expBusy  [2];
    logic       expDrop  [2];

    regfile_2r1w #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1'b0)) dut0 (
        .clk(clk), .clr(clr), .enable(enable), .wsel(wsel), .d(d),
        .rsel_a(rselA), .rsel_b(rselB), .qa(qa0), .qb(qb0),
        .init_req(initReq), .init_val(initVal), .busy(busy0), .wr_drop(drop0)
    );

    regfile_2r1w #(.WIDTH(8), .DEPTH(6), .ZERO_REG(1'b1)) dut1 (
        .clk(clk), .clr(clr), .enable(enable), .wsel(wsel), .d(d),
        .rsel_a(rselA), .rsel_b(rselB), .qa(qa1), .qb(qb1),
        .init_req(initReq), .init_val(initVal), .busy(busy1), .wr_drop(drop1)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] modelRead(input int k, input logic [2:0] sel);
        if (int'(sel) >= depthOf[k] || (zeroOf[k] && sel == 3'd0)) return 8'h00;
        return modelMem[k][sel];
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) modelMem[k][i] = 8'h00;
            fillLeft[k] = 0;
            fillVal[k]  = 8'h00;
            expQa[k]    = 8'h00;
            expQb[k]    = 8'h00;
            expBusy[k]  = 1'b0;
            expDrop[k]  = 1'b0;
        end
    endtask

    // Write-first reads fall out of updating the array before reading it back.
    task automatic modelStep();
        for (int k = 0; k < 2; k++) begin
            int idx;
            expDrop[k] = enable && (fillLeft[k] > 0 || int'(wsel) >= depthOf[k]);
            if (fillLeft[k] > 0) begin
                idx = depthOf[k] - fillLeft[k];
                if (!(zeroOf[k] && idx == 0)) modelMem[k][idx] = fillVal[k];
                fillLeft[k]--;
            end else begin
                if (enable && int'(wsel) < depthOf[k] && !(zeroOf[k] && wsel == 3'd0))
                    modelMem[k][wsel] = d;
                if (initReq) begin
                    fillLeft[k] = depthOf[k];
                    fillVal[k]  = initVal;
                end
            end
            expQa[k]   = modelRead(k, rselA);
            expQb[k]   = modelRead(k, rselB);
            expBusy[k] = (fillLeft[k] > 0);
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, " qa0"},   32'(qa0),   32'(expQa[0]));
        checkOutput({tag, " qb0"},   32'(qb0),   32'(expQb[0]));
        checkOutput({tag, " busy0"}, 32'(busy0), 32'(expBusy[0]));
        checkOutput({tag, " drop0"}, 32'(drop0), 32'(expDrop[0]));
        checkOutput({tag, " qa1"},   32'(qa1),   32'(expQa[1]));
        checkOutput({tag, " qb1"},   32'(qb1),   32'(expQb[1]));
        checkOutput({tag, " busy1"}, 32'(busy1), 32'(expBusy[1]));
        checkOutput({tag, " drop1"}, 32'(drop1), 32'(expDrop[1]));
    endtask

    task automatic applyStimulus(input logic en, input logic [2:0] ws, input logic [7:0] dd,
                                 input logic [2:0] ra, input logic [2:0] rb,
                                 input logic ir, input logic [7:0] iv);
        enable  = en;
        wsel    = ws;
        d       = dd;
        rselA   = ra;
        rselB   = rb;
        initReq = ir;
        initVal = iv;
        modelStep();
        @(posedge clk);
        #1;
        checkAll("cycle");
    endtask

    // Asynchronous: outputs must clear while clr is still high, well away from any clock edge.
    task automatic applyReset();
        clr = 1'b1;
        modelReset();
        #1;
        checkAll("reset");
        #1;
        clr = 1'b0;
    endtask

    initial begin
        VecT vec [6];
        int  busyCnt0;
        int  busyCnt1;

        vec[0] = '{1'b1, 3'd2, 8'hA5, 3'd3, 3'd7, 8'h00, 8'h00, 1'b0, 1'b0};
        vec[1] = '{1'b1, 3'd5, 8'h3C, 3'd2, 3'd5, 8'hA5, 8'h3C, 1'b0, 1'b0};
        vec[2] = '{1'b0, 3'd0, 8'h00, 3'd2, 3'd4, 8'hA5, 8'h00, 1'b0, 1'b0};
        vec[3] = '{1'b1, 3'd4, 8'h5A, 3'd4, 3'd5, 8'h5A, 8'h3C, 1'b0, 1'b0};
        vec[4] = '{1'b1, 3'd7, 8'h99, 3'd7, 3'd0, 8'h99, 8'h00, 1'b0, 1'b0};
        vec[5] = '{1'b0, 3'd0, 8'h00, 3'd5, 3'd2, 8'h3C, 8'hA5, 1'b0, 1'b0};

        clr = 1'b0; enable = 1'b0; initReq = 1'b0;
        wsel = 3'd0; rselA = 3'd3; rselB = 3'd7; d = 8'h00; initVal = 8'h00;
        modelReset();
        #3;
        applyReset();

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vec[i].en, vec[i].ws, vec[i].dd, vec[i].ra, vec[i].rb, 1'b0, 8'h00);
            checkOutput($sformatf("vec%0d qa", i),   32'(qa0),   32'(vec[i].expQa));
            checkOutput($sformatf("vec%0d qb", i),   32'(qb0),   32'(vec[i].expQb));
            checkOutput($sformatf("vec%0d drop", i), 32'(drop0), 32'(vec[i].expDrop));
            checkOutput($sformatf("vec%0d busy", i), 32'(busy0), 32'(vec[i].expBusy));
        end

        // Hardwired zero and out-of-range writes on the 6-deep instance.
        applyStimulus(1'b1, 3'd0, 8'h11, 3'd0, 3'd0, 1'b0, 8'h00);
        checkOutput("zero write drop", 32'(drop1), 32'd0);
        applyStimulus(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0, 8'h00);
        checkOutput("zero reg read", 32'(qa1), 32'd0);
        applyStimulus(1'b1, 3'd7, 8'h22, 3'd7, 3'd7, 1'b0, 8'h00);
        checkOutput("oob write drop", 32'(drop1), 32'd1);
        applyStimulus(1'b0, 3'd0, 8'h00, 3'd7, 3'd7, 1'b0, 8'h00);
        checkOutput("oob read", 32'(qa1), 32'd0);
        checkOutput("oob drop clears", 32'(drop1), 32'd0);

        // Bulk fill with a write attempted mid-sweep.
        applyStimulus(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1, 8'hFF);
        busyCnt0 = int'(busy0);
        busyCnt1 = int'(busy1);
        for (int c = 1; c <= 11; c++) begin
            applyStimulus(1'(c == 3), 3'd1, 8'h12, 3'(c), 3'(c + 3), 1'b0, 8'h00);
            if (c == 3) checkOutput("fill write drop", 32'(drop0), 32'd1);
            busyCnt0 += int'(busy0);
            busyCnt1 += int'(busy1);
        end
        checkOutput("busy length 8", 32'(busyCnt0), 32'd8);
        checkOutput("busy length 6", 32'(busyCnt1), 32'd6);
        for (int r = 0; r < 8; r++) begin
            applyStimulus(1'b0, 3'd0, 8'h00, 3'(r), 3'(7 - r), 1'b0, 8'h00);
            checkOutput($sformatf("fill rb%0d", r), 32'(qa0), 32'hFF);
            checkOutput($sformatf("fill rb1_%0d", r), 32'(qa1), (r >= 1 && r <= 5) ? 32'hFF : 32'h00);
        end

        // Reset in the middle of a sweep, then restart from index 0.
        applyStimulus(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1, 8'hC3);
        for (int c = 1; c <= 4; c++) applyStimulus(1'b0, 3'd0, 8'h00, 3'(c), 3'd0, 1'b0, 8'h00);
        applyReset();
        checkOutput("midsweep busy", 32'(busy0), 32'd0);
        for (int r = 0; r < 8; r++) begin
            applyStimulus(1'b0, 3'd0, 8'h00, 3'(r), 3'(r), 1'b0, 8'h00);
            checkOutput($sformatf("cleared rb%0d", r), 32'(qa0), 32'd0);
        end
        applyStimulus(1'b0, 3'd0, 8'h00, 3'd0, 3'd1, 1'b1, 8'h33);
        applyStimulus(1'b0, 3'd0, 8'h00, 3'd0, 3'd1, 1'b0, 8'h00);
        checkOutput("restart idx0", 32'(qa0), 32'h33);
        for (int c = 0; c < 8; c++) applyStimulus(1'b0, 3'd0, 8'h00, 3'(c), 3'(c), 1'b0, 8'h00);

        // Random traffic with occasional fills and resets.
        for (int n = 0; n < 400; n++) begin
            logic [2:0] ws;
            logic [2:0] rb;
            ws = 3'($urandom_range(0, 7));
            rb = ($urandom_range(0, 3) == 0) ? ws : 3'($urandom_range(0, 7));
            applyStimulus(1'($urandom_range(0, 1)), ws, 8'($urandom_range(0, 255)),
                          3'($urandom_range(0, 7)), rb,
                          1'($urandom_range(0, 15) == 0), 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 99) == 0) applyReset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
        $fatal(1, "[TB] timeout");
    end

endmodule
